// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/exec FSM driving a PC command port.
// Optional fetch timeout fault enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        cond_flag_i,
  input  logic        instr_valid_i,
  input  logic [15:0] instr_data_i,
  input  logic [15:0] pc_value_i,
  output logic [1:0]  pc_opcode_o,
  output logic [15:0] pc_target_o,
  output logic        mem_req_o,
  output logic        busy_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [15:0] instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_e;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] tgt_q, tgt_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        halt_q, halt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          flt_q, flt_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output logic; PC commands default to hold
  always_comb begin
    state_d = state_q;
    op_d    = OP_HOLD;
    tgt_d   = tgt_q;
    req_d   = req_q;
    busy_d  = busy_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
`ifdef PC_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    flt_d   = flt_q;
`endif
    unique case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start_i) begin
          state_d = S_SETTLE;
          op_d    = OP_CLR;
          cnt_d   = 16'h0000;
          req_d   = 1'b0;
          busy_d  = 1'b1;
          halt_d  = 1'b0;
`ifdef PC_SEQ_TIMEOUT_EN
          flt_d   = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
`ifdef PC_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_FETCH: begin
        if (instr_valid_i) begin
          ir_d    = instr_data_i;
          req_d   = 1'b0;
          state_d = S_EXEC;
`ifdef PC_SEQ_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAULT;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          flt_d   = 1'b1;
        end else begin
          tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      S_EXEC: begin
        if (!stall_i) begin
          state_d = S_SETTLE;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          unique case (ir_q[15:14])
            2'b00: op_d = OP_INC;
            2'b01: begin
              op_d  = OP_LOAD;
              tgt_d = {2'b00, ir_q[13:0]};
            end
            2'b10: begin
              if (cond_flag_i) begin
                op_d  = OP_LOAD;
                tgt_d = pc_value_i
                      + {{8{ir_q[7]}}, ir_q[7:0]};
              end else begin
                op_d  = OP_INC;
              end
            end
            default: begin
              state_d = S_HALT;
              busy_d  = 1'b0;
              halt_d  = 1'b1;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset wins over everything
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      tgt_q   <= 16'h0000;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= 16'h0000;
      ir_q    <= 16'h0000;
`ifdef PC_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
      flt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
`ifdef PC_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      flt_q   <= flt_d;
`endif
    end
  end

  assign pc_opcode_o   = op_q;
  assign pc_target_o   = tgt_q;
  assign mem_req_o     = req_q;
  assign busy_o        = busy_q;
  assign halted_o      = halt_q;
  assign instr_count_o = cnt_q;
`ifdef PC_SEQ_TIMEOUT_EN
  assign fault_o       = flt_q;
`else
  assign fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a PC-command scoreboard.
// Define PC_SEQ_TIMEOUT_EN to exercise the timeout fault path.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        cond_flag;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] pc_value;
  logic [1:0]  pc_opcode;
  logic [15:0] pc_target;
  logic        mem_req;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] tgt;
  } cmd_t;

  cmd_t sb[$];
  int   tests = 0;
  int   fails = 0;

  pc_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .start_i       (start),
    .stall_i       (stall),
    .cond_flag_i   (cond_flag),
    .instr_valid_i (instr_valid),
    .instr_data_i  (instr_data),
    .pc_value_i    (pc_value),
    .pc_opcode_o   (pc_opcode),
    .pc_target_o   (pc_target),
    .mem_req_o     (mem_req),
    .busy_o        (busy),
    .halted_o      (halted),
    .fault_o       (fault),
    .instr_count_o (instr_count)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; any non-hold PC command must match the queue head
  task automatic step();
    cmd_t e;
    @(posedge clock);
    #1;
    if (pc_opcode !== 2'b00) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected: got op %b want none", pc_opcode);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk16("sb_op", {14'd0, pc_opcode}, {14'd0, e.op});
        if (e.op == 2'b10)
          chk16("sb_tgt", pc_target, e.tgt);
      end
    end
  endtask

  // Starts in FETCH; runs one instruction through EXEC
  task automatic run(input string tag,
                     input logic [15:0] data,
                     input logic [15:0] pcv,
                     input logic cond,
                     input int nwait,
                     input int nstall,
                     input logic [1:0] eop,
                     input logic [15:0] etgt,
                     input logic [15:0] ecnt);
    cmd_t c;
    for (int i = 0; i < nwait; i++) begin
      step();
      chk1({tag, "_wait_req"}, mem_req, 1'b1);
    end
    instr_valid = 1'b1;
    instr_data  = data;
    step();
    chk1({tag, "_exec_req"}, mem_req, 1'b0);
    chk1({tag, "_exec_busy"}, busy, 1'b1);
    for (int i = 0; i < nstall; i++) begin
      stall       = 1'b1;
      instr_valid = 1'b1;
      instr_data  = 16'hC000;
      cond_flag   = ~cond;
      step();
      chk1({tag, "_stall_busy"}, busy, 1'b1);
    end
    stall       = 1'b0;
    instr_valid = 1'b0;
    pc_value    = pcv;
    cond_flag   = cond;
    if (eop != 2'b00) begin
      c.op  = eop;
      c.tgt = etgt;
      sb.push_back(c);
    end
    step();
    chk16({tag, "_sb_left"}, 16'(sb.size()), 16'd0);
    chk16({tag, "_count"}, instr_count, ecnt);
    if (eop == 2'b00) begin
      chk1({tag, "_halted"}, halted, 1'b1);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_req"}, mem_req, 1'b0);
    end else begin
      chk1({tag, "_settle_req"}, mem_req, 1'b0);
      step();
      chk1({tag, "_fetch_req"}, mem_req, 1'b1);
    end
  endtask

  initial begin
    cmd_t c;
    reset       = 1'b1;
    start       = 1'b0;
    stall       = 1'b0;
    cond_flag   = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 16'h0000;
    pc_value    = 16'h0000;
    repeat (2) step();
    chk16("rst_op", {14'd0, pc_opcode}, 16'd0);
    chk16("rst_tgt", pc_target, 16'h0000);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk16("rst_count", instr_count, 16'h0000);

    reset = 1'b0;
    start = 1'b1;
    c.op  = 2'b11;
    c.tgt = 16'h0000;
    sb.push_back(c);
    step();
    start = 1'b0;
    chk16("start_sb", 16'(sb.size()), 16'd0);
    chk1("settle_req", mem_req, 1'b0);
    chk1("settle_busy", busy, 1'b1);
    step();
    chk1("fetch_req", mem_req, 1'b1);
    chk1("fetch_busy", busy, 1'b1);

    start = 1'b1;
    step();
    start = 1'b0;
    chk1("start_ign_req", mem_req, 1'b1);

    run("nop", 16'h0000, 16'h0000, 1'b0, 2, 0,
        2'b01, 16'h0000, 16'h0001);
    run("jmp", 16'h4123, 16'h0001, 1'b0, 0, 0,
        2'b10, 16'h0123, 16'h0002);
    run("br_t", 16'h80FE, 16'h0001, 1'b1, 0, 0,
        2'b10, 16'hFFFF, 16'h0003);
    run("br_nt", 16'h80FE, 16'h0001, 1'b0, 1, 0,
        2'b01, 16'h0000, 16'h0004);
    run("stall", 16'h0000, 16'h0002, 1'b0, 0, 3,
        2'b01, 16'h0000, 16'h0005);
    run("br_fwd", 16'h8005, 16'h1000, 1'b1, 0, 0,
        2'b10, 16'h1005, 16'h0006);
    run("halt", 16'hC000, 16'h0000, 1'b0, 0, 0,
        2'b00, 16'h0000, 16'h0007);

    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk1("halt_hold", halted, 1'b1);
    chk16("halt_count", instr_count, 16'h0007);

    start = 1'b1;
    c.op  = 2'b11;
    sb.push_back(c);
    step();
    start = 1'b0;
    chk16("restart_count", instr_count, 16'h0000);
    chk1("restart_halted", halted, 1'b0);
    chk1("restart_busy", busy, 1'b1);
    step();

    for (int i = 0; i < 16; i++) step();
`ifdef PC_SEQ_TIMEOUT_EN
    chk1("tmo_fault", fault, 1'b1);
    chk1("tmo_req", mem_req, 1'b0);
    chk1("tmo_busy", busy, 1'b0);
    start = 1'b1;
    sb.push_back(c);
    step();
    start = 1'b0;
    chk1("tmo_clear", fault, 1'b0);
    step();
`else
    chk1("notmo_req", mem_req, 1'b1);
    chk1("notmo_fault", fault, 1'b0);
    chk1("notmo_busy", busy, 1'b1);
`endif

    reset       = 1'b1;
    start       = 1'b1;
    instr_valid = 1'b1;
    step();
    chk1("midrst_req", mem_req, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk16("midrst_op", {14'd0, pc_opcode}, 16'd0);
    reset       = 1'b0;
    start       = 1'b0;
    instr_valid = 1'b0;
    step();
    chk1("idle_req", mem_req, 1'b0);
    chk16("final_sb", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
